fifo_drain_savemod: RTL and testbench
=====================================

Name: fifo_drain_savemod

Overview:
- Sits directly downstream of the 1024x16 FIFO save stage and upstream of the SDRAM base module.
- Pops 16-bit words from the FIFO one at a time.
- Issues one single-word SDRAM write per word using the iCall/oDone handshake, at a linearly incrementing address that wraps.
- Keeps the FIFO drained so the capture side never sees Full while the SDRAM keeps up.

Parameters:
ADDR_W, 24, SDRAM word address width (bank 2 + row 13 + col 9).
ADDR_BASE, 24'd0, first write address after reset or iClear.
ADDR_LAST, 24'hFFFFFF, last write address; next address after it is ADDR_BASE.

Ports:
CLOCK  in  1  system clock; all logic on rising edge.
RESET  in  1  asynchronous, active-low reset.
iEnable  in  1  1 = drain permitted; 0 = hold in IDLE once the current write completes.
iClear  in  1  synchronous, level; returns pointer to ADDR_BASE and count to 0 (see Behaviour).
iTag  in  2  FIFO tags: [1] Full, [0] Empty.
iData  in  16  FIFO show-ahead head word; valid whenever iTag[0]=0.
oEn  out  1  FIFO pop strobe (top level ties it to FIFO iEn[0]); 1-cycle pulse.
oCall  out  2  SDRAM request: [1] write, [0] read (read always 0).
oAddr  out  ADDR_W  SDRAM write address; stable while oCall[1]=1.
oData  out  16  SDRAM write data; stable while oCall[1]=1.
iDone  in  1  SDRAM write complete; 1-cycle pulse.
oCount  out  ADDR_W  number of words written since reset/iClear; wraps modulo 2^ADDR_W.
oOverflow  out  1  sticky; set when iTag[1] (Full) is sampled 1.

Behaviour:
- Reset (RESET=0, asynchronous) drives all outputs to their reset values:
  - oEn=0, oCall=2'b00, oAddr=ADDR_BASE, oData=0, oCount=0, oOverflow=0.
  - State=IDLE.
- State machine, one state per cycle unless stated:
  - IDLE: if iEnable=1 and iTag[0]=0, then oData<=iData, oEn<=1 for exactly one cycle, go to CALL. Otherwise stay in IDLE.
  - CALL: oEn=0, oCall[1]=1. Hold until iDone=1 is sampled, then oCall[1]<=0 and go to NEXT.
  - NEXT: oAddr<=(oAddr==ADDR_LAST)?ADDR_BASE:oAddr+1; oCount<=oCount+1; go to IDLE.
- FIFO interaction:
  - The word is captured in the same cycle oEn pulses.
  - The FIFO head pointer advances on the following edge.
  - The Empty check in IDLE is therefore never made earlier than 2 cycles after a pop; the CALL and NEXT states guarantee this gap.
  - At most one pop per write. oEn is never asserted when iTag[0]=1.
- Timing:
  - Minimum loop is 3 cycles per word when iDone arrives on the first CALL cycle.
  - Latency from Empty falling (with iEnable=1) to oCall[1] rising: 1 cycle.
- iEnable:
  - Sampled only in IDLE.
  - Deasserting it during CALL/NEXT does not abort the transfer; the current word is always completed.
- iDone:
  - Ignored outside CALL.
  - A pulse in CALL coincident with the oCall[1] rising edge counts as completion.
- iClear:
  - In IDLE: takes effect on the next edge (oAddr<=ADDR_BASE, oCount<=0).
  - In CALL/NEXT: takes effect on entering IDLE, so the in-flight write keeps its address. The NEXT increment is discarded in favour of the clear.
  - Does not clear oOverflow.
- oOverflow: set on any cycle iTag[1]=1; cleared only by RESET.
- Address wrap: ADDR_LAST to ADDR_BASE in NEXT.
- oCount: wraps independently from 2^ADDR_W-1 to 0.
- Reset mid-CALL: oCall drops immediately (asynchronous). The pending word is lost, and the SDRAM core is reset by the same RESET.

Test Plan:
1. Reset then FIFO empty, iEnable=1 -> oEn never pulses; oCall=00; oAddr=0; oCount=0.
2. Preload 3 words 16'hA001, A002, A003, iEnable=1, iDone returned 4 cycles after each oCall[1] rise:
   - Exactly 3 oEn pulses.
   - Writes of A001@0, A002@1, A003@2.
   - oCount=3; then idle with Empty=1.
3. ADDR_BASE=0, ADDR_LAST=24'd3, stream 6 words -> addresses 0,1,2,3,0,1; oCount=6.
4. iEnable dropped in the cycle after oCall[1] rises -> the current write completes with iDone; no further oEn while iEnable=0; resumes on re-enable.
5. iClear pulsed during CALL at address 5 -> the write completes at address 5; the next write goes to ADDR_BASE; oCount restarts at 1 after that write.
6. Hold iDone low and fill FIFO until iTag[1]=1 -> oOverflow=1 and stays 1 after drain resumes; RESET pulled low mid-CALL -> oCall=00 and oOverflow=0 in the same cycle.

Source files
------------

// File: rtl/fifo_drain_savemod.sv
// Drains the capture FIFO into SDRAM, one single-word write per popped word,
// at a linearly incrementing wrapping address.
module fifo_drain_savemod #(
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] ADDR_BASE = 24'd0,
    parameter logic [ADDR_W-1:0] ADDR_LAST = 24'hFFFFFF
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              iEnable,
    input  logic              iClear,
    input  logic [1:0]        iTag,
    input  logic [15:0]       iData,
    output logic              oEn,
    output logic [1:0]        oCall,
    output logic [ADDR_W-1:0] oAddr,
    output logic [15:0]       oData,
    input  logic              iDone,
    output logic [ADDR_W-1:0] oCount,
    output logic              oOverflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALL = 2'd1,
        NEXT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              en_q, en_d;
    logic [15:0]       data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              clr_q, clr_d;
    logic              ovf_q, ovf_d;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            data_q  <= '0;
            addr_q  <= ADDR_BASE;
            count_q <= '0;
            clr_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            clr_q   <= clr_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        data_d  = data_q;
        addr_d  = addr_q;
        count_d = count_q;
        clr_d   = clr_q;
        ovf_d   = ovf_q | iTag[1];
        unique case (state_q)
            IDLE: begin
                if (iClear) begin
                    addr_d  = ADDR_BASE;
                    count_d = '0;
                end
                if (iEnable && !iTag[0]) begin
                    data_d  = iData;
                    en_d    = 1'b1;
                    state_d = CALL;
                end
            end
            CALL: begin
                // a clear here is deferred so the in-flight write keeps its address
                if (iClear) clr_d = 1'b1;
                if (iDone) state_d = NEXT;
            end
            NEXT: begin
                if (iClear || clr_q) begin
                    addr_d  = ADDR_BASE;
                    count_d = '0;
                end else begin
                    addr_d  = (addr_q == ADDR_LAST) ? ADDR_BASE
                                                    : addr_q + ADDR_W'(1);
                    count_d = count_q + ADDR_W'(1);
                end
                clr_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign oEn       = en_q;
    assign oCall     = {state_q == CALL, 1'b0};
    assign oAddr     = addr_q;
    assign oData     = data_q;
    assign oCount    = count_q;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_fifo_drain_savemod.sv
// Directed bench for fifo_drain_savemod with a small FIFO and SDRAM model.
// ADDR_LAST is set to 7 so address wrap is reachable.
module tb_fifo_drain_savemod;

    localparam int AW    = 24;
    localparam int DEPTH = 8;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b0;
    logic          iEnable = 1'b0;
    logic          iClear = 1'b0;
    logic [1:0]    iTag = 2'b01;
    logic [15:0]   iData = '0;
    logic          oEn;
    logic [1:0]    oCall;
    logic [AW-1:0] oAddr;
    logic [15:0]   oData;
    logic          iDone = 1'b0;
    logic [AW-1:0] oCount;
    logic          oOverflow;

    fifo_drain_savemod #(
        .ADDR_W   (AW),
        .ADDR_BASE(24'd0),
        .ADDR_LAST(24'd7)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .iEnable  (iEnable),
        .iClear   (iClear),
        .iTag     (iTag),
        .iData    (iData),
        .oEn      (oEn),
        .oCall    (oCall),
        .oAddr    (oAddr),
        .oData    (oData),
        .iDone    (iDone),
        .oCount   (oCount),
        .oOverflow(oOverflow)
    );

    always #5 CLOCK = ~CLOCK;

    int errors = 0;
    int checks = 0;
    int pops = 0;
    int cyc = 0;
    int cnt = 0;
    int done_lat = 4;
    logic [15:0] fq[$];
    logic [AW-1:0] wa[$];
    logic [15:0] wd[$];
    int wc[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        iTag[0] = (fq.size() == 0);
        iTag[1] = (fq.size() >= DEPTH);
        iData   = (fq.size() > 0) ? fq[0] : 16'h0;
    endtask

    task automatic step();
        logic en_s, call_s, done_s;
        logic [AW-1:0] a_s;
        logic [15:0] d_s;
        en_s = oEn; call_s = oCall[1]; done_s = iDone;
        a_s = oAddr; d_s = oData;
        @(posedge CLOCK);
        #1;
        cyc++;
        if (en_s) begin
            pops++;
            if (fq.size() > 0) fq.delete(0);
        end
        if (call_s && done_s) begin
            wa.push_back(a_s);
            wd.push_back(d_s);
            wc.push_back(cyc);
        end
        iDone = 1'b0;
        if (oCall[1]) begin
            if (!call_s) cnt = 0;
            else cnt++;
            if (done_lat >= 0 && cnt >= done_lat) iDone = 1'b1;
        end
        drive_fifo();
    endtask

    task automatic run_writes(input int n, input string tag);
        int b;
        b = 0;
        while (wa.size() < n && b < 200) begin
            step();
            b++;
        end
        chk({tag, "_timeout"}, 32'(wa.size() >= n), 32'd1);
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete();
        pops = 0;
    endtask

    initial begin
        logic [AW-1:0] ea[6];
        ea = '{24'd3, 24'd4, 24'd5, 24'd6, 24'd7, 24'd0};
        drive_fifo();
        #12;
        RESET = 1'b1;
        iEnable = 1'b1;

        // empty FIFO: nothing happens
        repeat (5) step();
        chk("t1_pops", 32'(pops), 0);
        chk("t1_call", 32'(oCall), 0);
        chk("t1_addr", 32'(oAddr), 0);
        chk("t1_count", 32'(oCount), 0);
        chk("t1_data", 32'(oData), 0);
        chk("t1_ovf", 32'(oOverflow), 0);

        // three words, iDone 4 cycles after call
        clear_log();
        done_lat = 4;
        fq.push_back(16'hA001); fq.push_back(16'hA002); fq.push_back(16'hA003);
        drive_fifo();
        step();
        chk("t2_lat_call", 32'(oCall), 32'h2);
        chk("t2_lat_en", 32'(oEn), 1);
        chk("t2_lat_data", 32'(oData), 32'hA001);
        step();
        chk("t2_en_pulse", 32'(oEn), 0);
        run_writes(3, "t2");
        repeat (6) step();
        chk("t2_pops", 32'(pops), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_addr%0d", i), 32'(wa[i]), 32'(i));
            chk($sformatf("t2_data%0d", i), 32'(wd[i]), 32'hA001 + 32'(i));
        end
        chk("t2_count", 32'(oCount), 3);
        chk("t2_idle_call", 32'(oCall), 0);

        // six words at minimum loop, wrapping past address 7
        clear_log();
        done_lat = 0;
        for (int i = 0; i < 6; i++) fq.push_back(16'hB000 + 16'(i));
        drive_fifo();
        run_writes(6, "t3");
        repeat (3) step();
        for (int i = 0; i < 6; i++)
            chk($sformatf("t3_addr%0d", i), 32'(wa[i]), 32'(ea[i]));
        chk("t3_data5", 32'(wd[5]), 32'hB005);
        chk("t3_loop", 32'(wc[1] - wc[0]), 3);
        chk("t3_count", 32'(oCount), 9);
        chk("t3_addr", 32'(oAddr), 1);

        // iEnable dropped right after call rises
        clear_log();
        done_lat = 2;
        fq.push_back(16'hC001); fq.push_back(16'hC002);
        drive_fifo();
        step();
        iEnable = 1'b0;
        run_writes(1, "t4a");
        repeat (10) step();
        chk("t4_held_pops", 32'(pops), 1);
        chk("t4_held_call", 32'(oCall), 0);
        chk("t4_addr0", 32'(wa[0]), 1);
        chk("t4_data0", 32'(wd[0]), 32'hC001);
        iEnable = 1'b1;
        run_writes(2, "t4b");
        repeat (3) step();
        chk("t4_addr1", 32'(wa[1]), 2);
        chk("t4_data1", 32'(wd[1]), 32'hC002);
        chk("t4_count", 32'(oCount), 11);

        // advance to address 5, then clear during the call
        clear_log();
        done_lat = 0;
        fq.push_back(16'hD003); fq.push_back(16'hD004);
        drive_fifo();
        run_writes(2, "t5a");
        repeat (3) step();
        chk("t5_pre_addr", 32'(oAddr), 5);
        clear_log();
        done_lat = 3;
        fq.push_back(16'hD005); fq.push_back(16'hD006);
        drive_fifo();
        step();
        iClear = 1'b1;
        step();
        iClear = 1'b0;
        run_writes(2, "t5b");
        repeat (3) step();
        chk("t5_addr0", 32'(wa[0]), 5);
        chk("t5_addr1", 32'(wa[1]), 0);
        chk("t5_data1", 32'(wd[1]), 32'hD006);
        chk("t5_count", 32'(oCount), 1);
        chk("t5_addr", 32'(oAddr), 1);

        // hold iDone, fill FIFO to Full, then release and reset mid-call
        clear_log();
        done_lat = -1;
        for (int i = 0; i < 9; i++) fq.push_back(16'hE000 + 16'(i));
        drive_fifo();
        repeat (4) step();
        chk("t6_ovf_set", 32'(oOverflow), 1);
        done_lat = 1;
        run_writes(3, "t6");
        repeat (2) step();
        chk("t6_ovf_sticky", 32'(oOverflow), 1);
        chk("t6_addr0", 32'(wa[0]), 1);
        chk("t6_data0", 32'(wd[0]), 32'hE000);
        begin
            int b;
            b = 0;
            while (!oCall[1] && b < 20) begin
                step();
                b++;
            end
            chk("t6_call_before_rst", 32'(oCall), 32'h2);
        end
        #2;
        RESET = 1'b0;
        #1;
        chk("t6_rst_call", 32'(oCall), 0);
        chk("t6_rst_ovf", 32'(oOverflow), 0);
        chk("t6_rst_addr", 32'(oAddr), 0);
        chk("t6_rst_count", 32'(oCount), 0);
        chk("t6_rst_en", 32'(oEn), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
